shift_cmd_queue: RTL and testbench
==================================

// Module: shift_cmd_queue
// PURPOSE
//   Command front-end for the 8-bit combinational barrel shifter: buffers shift
//   commands (din, shamt, ctrl, chain) in a small FIFO and issues one per cycle.
//   The shifter sits outside this block: its inputs are driven from sh_* and its
//   result is returned on sh_dout. Each result is registered and presented on a
//   valid/ready output. Chain mode reuses the previous result as the operand, so
//   multi-step shifts need no software round-trip.
// PARAMETERS
//   DEPTH   4   FIFO entries; power of two, >= 2
//   CNT_W   3   occupancy width, = $clog2(DEPTH+1)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      synchronous reset, active-low
//   in_valid   in   1      command valid
//   in_ready   out  1      command accepted when in_valid & in_ready at clk edge
//   in_din     in   8      operand (ignored when in_chain=1)
//   in_shamt   in   3      shift amount 0..7
//   in_ctrl    in   2      00 SHL, 01 SHR, 10 ROL, 11 ROR
//   in_chain   in   1      1: operand = last captured result
//   sh_din     out  8      to shifter din
//   sh_shamt   out  3      to shifter shamt
//   sh_ctrl    out  2      to shifter ctrl
//   sh_dout    in   8      from shifter dout (combinational path)
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer ready
//   out_data   out  8      registered shift result
//   count      out  CNT_W  FIFO occupancy 0..DEPTH (excludes output register)
// BEHAVIOUR
//   - Reset (rst_n=0 at edge): FIFO pointers=0, count=0, out_valid=0, out_data=0,
//     last_result=0. in_ready=1 in the first cycle after reset. Reset mid-operation
//     discards all queued commands and any held result; no partial output is produced.
//   - in_ready = (count != DEPTH). No simultaneous push+pop while full: a full FIFO
//     rejects input even if it pops in that same cycle.
//   - issue = (count != 0) & (!out_valid | out_ready).
//     On issue: pop head; out_data <= sh_dout; last_result <= sh_dout; out_valid <= 1.
//   - Otherwise, if out_valid & out_ready: out_valid <= 0.
//   - sh_din = head.chain ? last_result : head.din. sh_shamt and sh_ctrl come from head.
//     All sh_* are 0 when count==0.
//   - Latency: a command accepted at edge E is issued no earlier than edge E+1,
//     so out_valid rises after E+1. There is no empty-FIFO bypass.
//   - Throughput: 1 result/cycle while out_ready=1 and the FIFO is non-empty.
//   - Backpressure: while out_valid & !out_ready, out_data and last_result are
//     held and nothing is popped.
//   - Simultaneous push+pop (not full): count unchanged, both pointers advance.
//   - Pointers are $clog2(DEPTH) bits and wrap naturally. count is tracked separately.
//   - Chain reads last_result at issue time, i.e. the result of the immediately
//     preceding issued command, or 0 after reset.
//   - Command field widths are exact; this block performs no arithmetic on data.
// STRUCTURE
//   - Shared package shift_pkg: localparams SH_SHL=2'b00, SH_SHR=2'b01,
//     SH_ROL=2'b10, SH_ROR=2'b11; DATA_W=8, SHAMT_W=3, CTRL_W=2;
//     CMD_W=14 command packing {chain, ctrl, shamt, din}.
//   - Sub-module sync_fifo (WIDTH=CMD_W, DEPTH) with push/pop/full/empty/count.
//     The top level holds the issue logic, the output register and last_result.
// TESTING (bench instantiates the barrel shifter on sh_* / sh_dout)
//   1 Push {din=8'hB4, shamt=3, ROL, chain=0}, out_ready=1
//     -> out_valid rises after accept edge +1; out_data=8'hA5.
//   2 Push {8'h81, 1, SHL, 0} then {8'hFF, 2, ROR, 1}
//     -> out_data 8'h02, then 8'h80 (in_din 8'hFF ignored).
//   3 out_ready=0, in_valid=1 continuously for 6 cycles
//     -> 5 accepted (1 in out reg + 4 queued); count=4; in_ready=0; out_data constant.
//   4 Release out_ready=1 after test 3
//     -> 4 results on 4 consecutive cycles, then out_valid=0, count=0.
//   5 count=3 and out_valid=1, drive rst_n=0 for one edge
//     -> count=0, out_valid=0, in_ready=1; then push {8'hAA, 0, SHL, chain=1}
//     -> out_data=8'h00.
//   6 Push {8'h5A, 0, ROR, 0} and {8'h5A, 7, SHR, 0}
//     -> out_data 8'h5A, then 8'h00 (shamt boundaries).

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the shift command path: opcode encodings, field widths
// and the packed command word layout.
`default_nettype none

package shift_pkg;

   localparam logic [1:0] SH_SHL = 2'b00;
   localparam logic [1:0] SH_SHR = 2'b01;
   localparam logic [1:0] SH_ROL = 2'b10;
   localparam logic [1:0] SH_ROR = 2'b11;

   localparam int DATA_W  = 8;
   localparam int SHAMT_W = 3;
   localparam int CTRL_W  = 2;
   localparam int CMD_W   = 1 + CTRL_W + SHAMT_W + DATA_W;

   typedef struct packed {
      logic               chain;
      logic [CTRL_W-1:0]  ctrl;
      logic [SHAMT_W-1:0] shamt;
      logic [DATA_W-1:0]  din;
   } cmd_t;

endpackage

`default_nettype wire

// File: rtl/shift_cmd_queue_sync_fifo.sv
// Synchronous FIFO with separately tracked occupancy; head entry is visible
// combinationally on rd_data.
`default_nettype none

module sync_fifo #(
   parameter int WIDTH = 14,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Power-of-two depth lets the pointers wrap without explicit compare.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/shift_cmd_queue.sv
// Command front-end for an external barrel shifter: queues commands, issues one
// per cycle, registers each result on a valid/ready output, supports chaining.
`default_nettype none

module shift_cmd_queue
   import shift_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_din,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [CTRL_W-1:0]  in_ctrl,
   input  logic               in_chain,
   output logic [DATA_W-1:0]  sh_din,
   output logic [SHAMT_W-1:0] sh_shamt,
   output logic [CTRL_W-1:0]  sh_ctrl,
   input  logic [DATA_W-1:0]  sh_dout,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic [CNT_W-1:0]   count
);

   cmd_t              wr_cmd;
   cmd_t              head;
   logic [CMD_W-1:0]  head_bits;
   logic              fifo_full;
   logic              fifo_empty;
   logic              issue;
   logic [DATA_W-1:0] last_result;

   assign wr_cmd   = '{chain: in_chain, ctrl: in_ctrl, shamt: in_shamt, din: in_din};
   assign head     = cmd_t'(head_bits);
   assign in_ready = !fifo_full;
   assign issue    = !fifo_empty && (!out_valid || out_ready);

   sync_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (in_valid && in_ready),
      .wr_data (wr_cmd),
      .pop     (issue),
      .rd_data (head_bits),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (count)
   );

   // Drive the shifter only from a real head entry so stale RAM never leaks out.
   always_comb begin
      sh_din   = '0;
      sh_shamt = '0;
      sh_ctrl  = '0;
      if (!fifo_empty) begin
         sh_din   = head.chain ? last_result : head.din;
         sh_shamt = head.shamt;
         sh_ctrl  = head.ctrl;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_data    <= '0;
         last_result <= '0;
      end else if (issue) begin
         out_valid   <= 1'b1;
         out_data    <= sh_dout;
         last_result <= sh_dout;
      end else if (out_valid && out_ready) begin
         out_valid   <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_shift_cmd_queue.sv
// Self-checking bench: directed vector table, corner sequences, and random
// traffic checked against a queue-based reference model.
`default_nettype none

module tb_shift_cmd_queue;
   import shift_pkg::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_din;
   logic [2:0]       in_shamt;
   logic [1:0]       in_ctrl;
   logic             in_chain;
   logic [7:0]       sh_din;
   logic [2:0]       sh_shamt;
   logic [1:0]       sh_ctrl;
   logic [7:0]       sh_dout;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_data;
   logic [CNT_W-1:0] count;

   always #5 clk = ~clk;

   function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] s,
                                            input logic [1:0] c);
      logic [15:0] dbl;
      logic [15:0] t;
      dbl = {d, d};
      case (c)
         SH_SHL:  return d << s;
         SH_SHR:  return d >> s;
         SH_ROL:  begin t = dbl << s; return t[15:8]; end
         default: begin t = dbl >> s; return t[7:0]; end
      endcase
   endfunction

   // Barrel shifter standing in for the external datapath.
   assign sh_dout = ref_shift(sh_din, sh_shamt, sh_ctrl);

   shift_cmd_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_din    (in_din),
      .in_shamt  (in_shamt),
      .in_ctrl   (in_ctrl),
      .in_chain  (in_chain),
      .sh_din    (sh_din),
      .sh_shamt  (sh_shamt),
      .sh_ctrl   (sh_ctrl),
      .sh_dout   (sh_dout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count)
   );

   typedef struct {
      logic [7:0] din;
      logic [2:0] shamt;
      logic [1:0] ctrl;
      bit         chain;
   } mcmd_t;

   mcmd_t      q[$];
   bit         m_valid;
   logic [7:0] m_data;
   logic [7:0] m_last;

   int tests = 0;
   int fails = 0;
   int dut_acc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive, check combinational outputs, advance model, check registers.
   task automatic step(input bit v, input logic [7:0] d, input logic [2:0] s,
                       input logic [1:0] c, input bit ch, input bit ordy, input bit rst);
      mcmd_t h;
      mcmd_t n;
      bit acc;
      bit iss;
      logic [7:0] op;
      @(negedge clk);
      rst_n = !rst; in_valid = v; in_din = d; in_shamt = s; in_ctrl = c;
      in_chain = ch; out_ready = ordy;
      #1;
      chk("in_ready", in_ready, q.size() != DEPTH);
      if (q.size() != 0) begin
         h  = q[0];
         op = h.chain ? m_last : h.din;
         chk("sh_din", sh_din, op);
         chk("sh_shamt", sh_shamt, h.shamt);
         chk("sh_ctrl", sh_ctrl, h.ctrl);
      end else begin
         chk("sh_idle", {sh_din, sh_shamt, sh_ctrl}, 0);
      end
      if (v && in_ready) dut_acc++;
      @(posedge clk);
      if (rst) begin
         q.delete(); m_valid = 0; m_data = 0; m_last = 0;
      end else begin
         acc = v && (q.size() < DEPTH);
         iss = (q.size() != 0) && (!m_valid || ordy);
         if (iss) begin
            h = q.pop_front();
            op = h.chain ? m_last : h.din;
            m_data = ref_shift(op, h.shamt, h.ctrl);
            m_last = m_data;
            m_valid = 1;
         end else if (m_valid && ordy) begin
            m_valid = 0;
         end
         if (acc) begin
            n.din = d; n.shamt = s; n.ctrl = c; n.chain = ch;
            q.push_back(n);
         end
      end
      #1;
      chk("out_valid", out_valid, m_valid);
      chk("out_data", out_data, m_data);
      chk("count", count, q.size());
   endtask

   typedef struct {
      logic [7:0] din;
      logic [2:0] shamt;
      logic [1:0] ctrl;
      bit         chain;
      logic [7:0] exp;
   } vec_t;

   vec_t       vecs[5];
   logic [7:0] held;

   initial begin
      vecs[0] = '{8'hB4, 3'd3, SH_ROL, 1'b0, 8'hA5};
      vecs[1] = '{8'h81, 3'd1, SH_SHL, 1'b0, 8'h02};
      vecs[2] = '{8'hFF, 3'd2, SH_ROR, 1'b1, 8'h80};
      vecs[3] = '{8'h5A, 3'd0, SH_ROR, 1'b0, 8'h5A};
      vecs[4] = '{8'h5A, 3'd7, SH_SHR, 1'b0, 8'h00};

      rst_n = 0; in_valid = 0; in_din = 0; in_shamt = 0; in_ctrl = 0;
      in_chain = 0; out_ready = 0;
      q.delete(); m_valid = 0; m_data = 0; m_last = 0;
      step(0, 0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0, 1, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_count", count, 0);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_data", out_data, 0);

      // Directed table: single commands with an always-ready consumer.
      for (int i = 0; i < 5; i++) begin
         step(1, vecs[i].din, vecs[i].shamt, vecs[i].ctrl, vecs[i].chain, 1, 0);
         chk("vec_latency", out_valid, 0);
         step(0, 0, 0, 0, 0, 1, 0);
         chk("vec_valid", out_valid, 1);
         chk("vec_data", out_data, vecs[i].exp);
         step(0, 0, 0, 0, 0, 1, 0);
      end

      // Backpressure fill: one result held, four queued, sixth rejected.
      dut_acc = 0;
      for (int i = 0; i < 6; i++) begin
         step(1, 8'(i * 37 + 1), 3'(i), 2'(i), 0, 0, 0);
         if (i == 1) held = out_data;
         if (i > 1) chk("t3_held", out_data, held);
      end
      chk("t3_accepted", dut_acc, 5);
      chk("t3_count", count, 4);
      chk("t3_in_ready", in_ready, 0);

      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 0, 0, 1, 0);
         chk("t4_stream", out_valid, 1);
      end
      step(0, 0, 0, 0, 0, 1, 0);
      chk("t4_drained_valid", out_valid, 0);
      chk("t4_drained_count", count, 0);

      // Reset with three queued and a held result, then chain from cleared state.
      for (int i = 0; i < 4; i++) step(1, 8'hC3, 3'd1, SH_ROL, 0, 0, 0);
      chk("t5_pre_count", count, 3);
      chk("t5_pre_valid", out_valid, 1);
      step(0, 0, 0, 0, 0, 0, 1);
      chk("t5_count", count, 0);
      chk("t5_valid", out_valid, 0);
      chk("t5_in_ready", in_ready, 1);
      step(1, 8'hAA, 3'd0, SH_SHL, 1, 1, 0);
      step(0, 0, 0, 0, 0, 1, 0);
      chk("t5_chain_valid", out_valid, 1);
      chk("t5_chain_data", out_data, 8'h00);
      step(0, 0, 0, 0, 0, 1, 0);

      // Random traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         step(bit'($urandom_range(0, 99) < 60), 8'($urandom), 3'($urandom),
              2'($urandom), bit'($urandom_range(0, 2) == 0),
              bit'($urandom_range(0, 99) < 55), $urandom_range(0, 99) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
